// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared types and default timing constants for the FMC424 I2C core
// Revision : 1.0  initial release
// ============================================================================
package i2c_pkg;

   localparam int CLK_HZ        = 156_250_000;
   localparam int SCL_HZ        = 400_000;
   localparam int LOW_CYCLES    = 210;
   localparam int HIGH_CYCLES   = 180;
   localparam int SETTLE_CYCLES = 3;
   localparam int CNT_W         = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer presetting to 1 (idle level of an I2C line)
// Revision : 1.0  initial release
// ============================================================================
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_gen
// Purpose  : Open-drain SCL generator with slave clock stretching and phase strobes
// Revision : 1.0  initial release
// ============================================================================
module clk_gen #(
   parameter int LOW_CYCLES    = i2c_pkg::LOW_CYCLES,
   parameter int HIGH_CYCLES   = i2c_pkg::HIGH_CYCLES,
   parameter int SETTLE_CYCLES = i2c_pkg::SETTLE_CYCLES
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic en,
   input  logic scl_i,
   output logic scl_t,
   output logic scl_fall,
   output logic scl_low_mid,
   output logic scl_rise,
   output logic scl_high_mid,
   output logic stretching,
   output logic busy
);

   import i2c_pkg::*;

   localparam logic [CNT_W-1:0] c_LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_LOW_MID   = CNT_W'(LOW_CYCLES / 2);
   localparam logic [CNT_W-1:0] c_HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_HIGH_MID  = CNT_W'(HIGH_CYCLES / 2);
   localparam logic [CNT_W-1:0] c_SETTLE    = CNT_W'(SETTLE_CYCLES);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_en;
   logic             w_scl_s;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_hold;

   sync_2ff u_scl_sync (
      .clk   (CLK),
      .rst_n (RST_N),
      .i_d   (scl_i),
      .o_q   (w_scl_s)
   );

   assign w_cnt_inc = r_cnt + CNT_W'(1);
   // A slave holding SCL low freezes HIGH once the release has had time to settle
   assign w_hold    = (r_state == HIGH) && (r_cnt >= c_SETTLE) && !w_scl_s;

   // Outputs are written alongside the state update so they line up with r_state
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_en         <= 1'b0;
         scl_t        <= 1'b1;
         scl_fall     <= 1'b0;
         scl_low_mid  <= 1'b0;
         scl_rise     <= 1'b0;
         scl_high_mid <= 1'b0;
         stretching   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         r_en         <= en;
         scl_fall     <= 1'b0;
         scl_low_mid  <= 1'b0;
         scl_rise     <= 1'b0;
         scl_high_mid <= 1'b0;
         stretching   <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (r_en) begin
                  r_state  <= LOW;
                  scl_t    <= 1'b0;
                  scl_fall <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            LOW: begin
               // LOW always runs to completion, even if en has dropped
               if (r_cnt == c_LOW_LAST) begin
                  r_state  <= HIGH;
                  r_cnt    <= '0;
                  scl_t    <= 1'b1;
                  scl_rise <= 1'b1;
               end else begin
                  r_cnt       <= w_cnt_inc;
                  scl_low_mid <= (w_cnt_inc == c_LOW_MID);
               end
            end
            HIGH: begin
               if (w_hold) begin
                  stretching <= 1'b1;
               end else if (r_cnt == c_HIGH_LAST) begin
                  r_cnt <= '0;
                  if (r_en) begin
                     r_state  <= LOW;
                     scl_t    <= 1'b0;
                     scl_fall <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                     busy    <= 1'b0;
                  end
               end else begin
                  r_cnt        <= w_cnt_inc;
                  scl_high_mid <= (w_cnt_inc == c_HIGH_MID);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               scl_t   <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gen
// Purpose  : Self-checking bench for clk_gen: vector table plus corner sequences
// Revision : 1.0  initial release
// ============================================================================
module tb_clk_gen;

   logic CLK;
   logic RST_N;
   logic en;
   logic ext_low;
   logic scl_i;
   logic scl_t, scl_fall, scl_low_mid, scl_rise, scl_high_mid, stretching, busy;
   logic [6:0] obs;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         n;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl[14];

   localparam logic [6:0] IDLE_VEC = 7'b1000000;

   // Zero-delay pull-up: pin is high only when released and not held by the "slave"
   assign scl_i = scl_t & ~ext_low;
   assign obs   = {scl_t, scl_fall, scl_low_mid, scl_rise, scl_high_mid, stretching, busy};

   clk_gen dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .en           (en),
      .scl_i        (scl_i),
      .scl_t        (scl_t),
      .scl_fall     (scl_fall),
      .scl_low_mid  (scl_low_mid),
      .scl_rise     (scl_rise),
      .scl_high_mid (scl_high_mid),
      .stretching   (stretching),
      .busy         (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      int n, lo, hi, st, hm_off, k;
      int falls, rises, lmids, hmids, runs, bad_runs, bad_place, run, last_fall, last_rise;
      logic prev_t;

      // obs = {scl_t, fall, low_mid, rise, high_mid, stretching, busy}; n = cycles after en set
      tbl[0]  = '{1,   7'b1000000};
      tbl[1]  = '{2,   7'b0100001};
      tbl[2]  = '{3,   7'b0000001};
      tbl[3]  = '{106, 7'b0000001};
      tbl[4]  = '{107, 7'b0010001};
      tbl[5]  = '{108, 7'b0000001};
      tbl[6]  = '{211, 7'b0000001};
      tbl[7]  = '{212, 7'b1001001};
      tbl[8]  = '{213, 7'b1000001};
      tbl[9]  = '{301, 7'b1000001};
      tbl[10] = '{302, 7'b1000101};
      tbl[11] = '{303, 7'b1000001};
      tbl[12] = '{391, 7'b1000001};
      tbl[13] = '{392, 7'b0100001};

      RST_N   = 1'b0;
      en      = 1'b0;
      ext_low = 1'b0;
      repeat (20) tick();
      check("reset_outputs", 32'(obs), 32'(IDLE_VEC));
      #2 RST_N = 1'b1;
      repeat (5) tick();
      check("idle_en0", 32'(obs), 32'(IDLE_VEC));

      en = 1'b1;
      n  = 0;
      for (int i = 0; i < 14; i++) begin
         while (n < tbl[i].n) begin
            tick();
            n++;
         end
         check($sformatf("vec_n%0d", tbl[i].n), 32'(obs), 32'(tbl[i].exp));
      end

      // 25 continuous periods starting on the current scl_fall cycle
      falls = 0; rises = 0; lmids = 0; hmids = 0;
      runs = 0; bad_runs = 0; bad_place = 0;
      run = 0; prev_t = 1'b0; last_fall = 0; last_rise = 0;
      for (int i = 0; i < 9750; i++) begin
         if (i > 0) tick();
         if (i > 0 && scl_t != prev_t) begin
            runs++;
            if (prev_t == 1'b0 && run != 210) bad_runs++;
            if (prev_t == 1'b1 && run != 180) bad_runs++;
            run = 0;
         end
         run++;
         prev_t = scl_t;
         if (scl_fall) begin falls++; last_fall = i; end
         if (scl_rise) begin rises++; last_rise = i; end
         if (scl_low_mid) begin
            lmids++;
            if (i - last_fall != 105) bad_place++;
         end
         if (scl_high_mid) begin
            hmids++;
            if (i - last_rise != 90) bad_place++;
         end
      end
      check("run_falls", 32'(falls), 32'd25);
      check("run_rises", 32'(rises), 32'd25);
      check("run_low_mids", 32'(lmids), 32'd25);
      check("run_high_mids", 32'(hmids), 32'd25);
      check("run_phase_count", 32'(runs), 32'd49);
      check("run_bad_phase_len", 32'(bad_runs), 32'd0);
      check("run_bad_strobe_place", 32'(bad_place), 32'd0);

      tick();
      check("next_fall", 32'(scl_fall), 32'd1);

      // Stretch: slave holds SCL low for 100 cycles starting at the release
      lo = 0;
      while (scl_t == 1'b0 && lo < 1000) begin
         lo++;
         tick();
      end
      check("stretch_low_len", 32'(lo), 32'd210);
      check("stretch_rise", 32'(scl_rise), 32'd1);
      ext_low = 1'b1;
      hi = 0; st = 0; hm_off = -1; k = 0;
      while (scl_t == 1'b1 && k < 2000) begin
         if (k == 100) ext_low = 1'b0;
         if (stretching) st++;
         if (scl_high_mid) hm_off = k;
         hi++;
         tick();
         k++;
      end
      ext_low = 1'b0;
      check("stretch_high_len", 32'(hi), 32'd279);
      check("stretch_cycles", 32'(st), 32'd99);
      check("stretch_high_mid_off", 32'(hm_off), 32'd189);
      check("stretch_period", 32'(lo + hi), 32'd489);
      check("stretch_next_fall", 32'(scl_fall), 32'd1);

      // Drop en at LOW count 50: period completes, then idle released
      lo = 0; hi = 0; k = 0;
      while (busy && k < 2000) begin
         if (k == 50) en = 1'b0;
         if (scl_t == 1'b0) lo++;
         else hi++;
         tick();
         k++;
      end
      check("stop_low_len", 32'(lo), 32'd210);
      check("stop_high_len", 32'(hi), 32'd180);
      check("stop_idle_outputs", 32'(obs), 32'(IDLE_VEC));
      falls = 0; lo = 0;
      repeat (500) begin
         tick();
         if (scl_fall) falls++;
         if (scl_t == 1'b0) lo++;
      end
      check("stop_no_fall", 32'(falls), 32'd0);
      check("stop_no_low", 32'(lo), 32'd0);

      // Asynchronous reset at LOW count 100
      en = 1'b1;
      k  = 0;
      while (!scl_fall && k < 10) begin
         tick();
         k++;
      end
      check("restart_fall", 32'(scl_fall), 32'd1);
      repeat (100) tick();
      check("pre_reset_low", 32'(scl_t), 32'd0);
      #1 RST_N = 1'b0;
      #1;
      check("async_reset_outputs", 32'(obs), 32'(IDLE_VEC));
      repeat (3) tick();
      #2 RST_N = 1'b1;
      tick();
      check("post_reset_edge1", 32'(obs), 32'(IDLE_VEC));
      tick();
      check("post_reset_edge2_fall", 32'(obs), 32'(7'b0100001));
      lo = 0;
      while (scl_t == 1'b0 && lo < 1000) begin
         lo++;
         tick();
      end
      check("post_reset_low_len", 32'(lo), 32'd210);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clk_gen.md
# clk_gen

SCL clock generator for the FMC424 I2C controller. Divides the 156.25 MHz fabric clock (`CLK`) down to a 400 kHz fast-mode SCL. SCL is driven as an open-drain tristate enable. The block supports clock stretching by slaves and emits phase strobes that the I2C bit/byte engine uses to launch and sample SDA.

## Interface
- `LOW_CYCLES`, default 210: CLK cycles SCL is held low (1.344 µs ≥ 1.3 µs tLOW).
- `HIGH_CYCLES`, default 180: CLK cycles SCL is released when not stretched (1.152 µs ≥ 0.6 µs tHIGH). Sum 390 gives 400.6 kHz.
- `SETTLE_CYCLES`, default 3: HIGH-phase cycles during which `scl_i` is ignored (rise time plus synchronizer).
- `CLK` input 1: fabric clock, 156.25 MHz.
- `RST_N` input 1: one clock; reset is asynchronous and active-low.
- `en` input 1: run request.
- `scl_i` input 1: SCL pin readback, asynchronous.
- `scl_t` output 1: tristate enable. 1 = release (pin Z, pulled high); 0 = drive pin low.
- `scl_fall` output 1: one-cycle pulse on the first cycle `scl_t`=0.
- `scl_low_mid` output 1: one-cycle pulse at LOW count `LOW_CYCLES/2` (105). This is the SDA change point.
- `scl_rise` output 1: one-cycle pulse on the first cycle `scl_t`=1 after LOW.
- `scl_high_mid` output 1: one-cycle pulse at HIGH count `HIGH_CYCLES/2` (90). This is the SDA sample point.
- `stretching` output 1: high while the HIGH counter is frozen by a low `scl_i`.
- `busy` output 1: high in any state other than IDLE.

## Operation
- `scl_i` passes through a 2-flop synchronizer (`scl_s`). Both flops reset to 1.
- Counter is 9 bits, reset to 0 on every state entry.
- IDLE: `scl_t`=1, counter 0. If `en`=1, the next state is LOW.
- LOW: `scl_t`=0. Counter counts 0..`LOW_CYCLES`-1.
  - At the last count: if `en`=1 or a period is in progress, go to HIGH.
- HIGH: `scl_t`=1. Counter counts 0..`HIGH_CYCLES`-1.
  - While count ≥ `SETTLE_CYCLES` and `scl_s`=0, the counter holds and `stretching`=1.
  - At the last count: if `en`=1, go to LOW; otherwise go to IDLE.
- Dropping `en` mid-period always finishes the current LOW+HIGH period and stops with SCL released. A partial LOW is never truncated.
- Stretching has no limit. The counter resumes on the cycle `scl_s` returns high.
- All outputs are registered and decoded from state/counter. Strobes never assert in IDLE.
- Reset values: `scl_t`=1; `scl_fall`, `scl_rise`, `scl_low_mid`, `scl_high_mid`, `stretching`, `busy` all 0. State is IDLE.

## Timing
- `en` sampled high in IDLE at edge k: `scl_t`=0 and `scl_fall`=1 after edge k+1.
- Unstretched period is exactly 390 CLK cycles: 210 with `scl_t`=0, then 180 with `scl_t`=1.
- Stretch arithmetic: external low held for N ≥ 3 cycles after release extends HIGH by N−1 cycles (2-cycle synchronizer latency, first 3 cycles ignored). Hold of N ≤ 1 adds nothing.
- `scl_fall`/`scl_rise` coincide with the first cycle of the new `scl_t` value.
- `scl_low_mid` fires 105 cycles after `scl_fall`. `scl_high_mid` fires 90 counted (non-frozen) cycles after `scl_rise`.
- `RST_N` low at any time:
  - `scl_t`=1 immediately, without waiting for CLK, even mid-LOW.
  - Strobes clear.
  - Synchronizer presets to 1.
- After `RST_N` deasserts, the first period starts no earlier than the second CLK edge, and only if `en`=1.

## Structure
- Package `i2c_pkg`:
  - state enum (`IDLE`, `LOW`, `HIGH`);
  - default constants `CLK_HZ`=156_250_000, `SCL_HZ`=400_000, `LOW_CYCLES`, `HIGH_CYCLES`;
  - counter width (9).
- One sub-module: `sync_2ff`, a reset-to-1 two-flop synchronizer for `scl_i`. Shared later with the SDA readback.

## Test plan
- Reset with `en`=0 for 20 cycles: `scl_t`=1, all strobes 0, `busy`=0, pin reads Z.
- `en`=1 continuous, `scl_i` follows the pin with a 0-cycle pull-up: `scl_t` low 210, high 180, period 390. Over 25 periods (9750 cycles), 25 pulses each of `scl_fall`, `scl_rise`, `scl_low_mid`, `scl_high_mid`.
- Strobe placement: `scl_low_mid` exactly 105 cycles after `scl_fall`; `scl_high_mid` exactly 90 cycles after `scl_rise`.
- Stretch: hold `scl_i` low for 100 cycles after release:
  - `stretching`=1 for 99 cycles;
  - HIGH phase lasts 279 cycles, period 489;
  - `scl_high_mid` delayed by 99.
- Drop `en` at LOW count 50: the LOW completes (210), HIGH completes (180), then IDLE with `scl_t`=1 and `busy`=0. No further `scl_fall`.
- Assert `RST_N`=0 at LOW count 100: `scl_t`=1 before the next CLK edge. After release with `en`=1, a fresh full 210-cycle LOW follows.
